// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB plus saturating direction counters, with optional gshare index.
// Lookup latency 0 (combinational from f_pc); update latency 1 (visible the cycle after the update edge).
// No backpressure: one update per enabled edge; enable=0 freezes all state while lookup stays live.
// Optional feature macro: BRANCH_PREDICTOR_GSHARE_EN (XOR global history into the counter index).
module branch_predictor #(
  parameter int PC_W    = 8,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 4,
  parameter int STAT_W  = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [PC_W-1:0]   f_pc,
  output logic              f_hit,
  output logic              f_taken,
  output logic [PC_W-1:0]   f_next_pc,
  output logic [IDX_W-1:0]  f_index,
  input  logic              u_valid,
  input  logic [PC_W-1:0]   u_pc,
  input  logic [IDX_W-1:0]  u_index,
  input  logic              u_taken,
  input  logic [PC_W-1:0]   u_target,
  input  logic              u_pred,
  output logic              u_mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int TAG_W = PC_W - IDX_W;

  // Weakly not-taken start point: just below the taken threshold (0 for 1-bit counters).
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

  // Branch target buffer, one entry per slot.
  logic              btb_valid_q [ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q   [ENTRIES];
  logic [PC_W-1:0]   btb_tgt_q   [ENTRIES];
  logic              btb_valid_d [ENTRIES];
  logic [TAG_W-1:0]  btb_tag_d   [ENTRIES];
  logic [PC_W-1:0]   btb_tgt_d   [ENTRIES];

  // Direction counters, indexed separately from the BTB so gshare can reshuffle them.
  logic [CTR_W-1:0]  ctr_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_d [ENTRIES];

  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

  logic              upd_fire;
  logic [IDX_W-1:0]  f_slot;
  logic [TAG_W-1:0]  f_tag;
  logic [IDX_W-1:0]  u_slot;
  logic [TAG_W-1:0]  u_tag;
  logic [CTR_W-1:0]  f_ctr;
  logic [CTR_W-1:0]  u_ctr;

  assign f_slot = f_pc[IDX_W-1:0];
  assign f_tag  = f_pc[PC_W-1:IDX_W];
  assign u_slot = u_pc[IDX_W-1:0];
  assign u_tag  = u_pc[PC_W-1:IDX_W];

  // Reset is handled in the register block, so an update only needs enable and valid here.
  assign upd_fire     = u_valid & enable;
  assign u_mispredict = u_valid & (u_pred != u_taken);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // Counter index mixes the low PC bits with the global outcome history.
  assign f_index = f_slot ^ IDX_W'(ghr_q);

  // History shifts in the resolved outcome on every accepted update.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_fire) begin
      ghr_d = GHR_W'({ghr_q, u_taken});
    end
  end

  // History register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  // Counter table indexed by PC alone.
  assign f_index = f_slot;
`endif

  // Combinational lookup against the current (pre-update) state; no bypass from the update port.
  always_comb begin
    f_ctr     = ctr_q[f_index];
    f_hit     = btb_valid_q[f_slot] && (btb_tag_q[f_slot] == f_tag);
    f_taken   = f_hit & f_ctr[CTR_W-1];
    f_next_pc = f_taken ? btb_tgt_q[f_slot] : f_pc + PC_W'(1);
  end

  // Next-state for tables and statistics: counter nudges toward the outcome, BTB allocates only on taken.
  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    ctr_d       = ctr_q;
    stat_br_d   = stat_br_q;
    stat_mp_d   = stat_mp_q;
    u_ctr       = ctr_q[u_index];
    if (upd_fire) begin
      if (u_taken) begin
        if (u_ctr != CTR_MAX) begin
          ctr_d[u_index] = u_ctr + CTR_W'(1);
        end
        btb_valid_d[u_slot] = 1'b1;
        btb_tag_d[u_slot]   = u_tag;
        btb_tgt_d[u_slot]   = u_target;
      end else begin
        if (u_ctr != '0) begin
          ctr_d[u_index] = u_ctr - CTR_W'(1);
        end
      end
      if (stat_br_q != {STAT_W{1'b1}}) begin
        stat_br_d = stat_br_q + STAT_W'(1);
      end
      if (u_mispredict && (stat_mp_q != {STAT_W{1'b1}})) begin
        stat_mp_d = stat_mp_q + STAT_W'(1);
      end
    end
  end

  // State registers; reset wins over any concurrent update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
        ctr_q[i]       <= CTR_INIT;
      end
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      btb_valid_q <= btb_valid_d;
      btb_tag_q   <= btb_tag_d;
      btb_tgt_q   <= btb_tgt_d;
      ctr_q       <= ctr_d;
      stat_br_q   <= stat_br_d;
      stat_mp_q   <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined core's fetch stage. Replaces the fixed single-counter prediction unit. It has three parts: a direct-mapped branch target buffer (BTB), a table of saturating direction counters, and an optional gshare global-history index. The fetch stage reads it combinationally to choose the next PC. The decode stage updates it once the branch outcome is resolved, and it keeps resolved-branch and misprediction statistics.

## Interface
Parameters:
- `PC_W`, 8, PC/instruction-address width.
- `ENTRIES`, 16, number of BTB and counter-table entries. Power of two, ≥2. `IDX_W = log2(ENTRIES)`, `TAG_W = PC_W - IDX_W`.
- `CTR_W`, 2, direction counter width, ≥1.
- `GHR_W`, 4, global history length, ≤`IDX_W`. Used only with `GSHARE_EN`.
- `STAT_W`, 16, statistics counter width.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: global hold. When low, no state changes.
- `f_pc`, in, PC_W: fetch address to predict.
- `f_hit`, out, 1: BTB entry valid and tag matches `f_pc`.
- `f_taken`, out, 1: predicted taken.
- `f_next_pc`, out, PC_W: predicted next PC.
- `f_index`, out, IDX_W: counter-table index used for this lookup. The pipeline carries it to decode.
- `u_valid`, in, 1: a resolved branch is presented for update.
- `u_pc`, in, PC_W: address of the resolved branch.
- `u_index`, in, IDX_W: `f_index` captured when this branch was fetched.
- `u_taken`, in, 1: actual outcome.
- `u_target`, in, PC_W: actual taken target.
- `u_pred`, in, 1: `f_taken` captured when this branch was fetched.
- `u_mispredict`, out, 1: `u_valid & (u_pred != u_taken)`. Combinational; drives the IF/ID flush.
- `stat_branches`, out, STAT_W: count of resolved branches.
- `stat_mispredicts`, out, STAT_W: count of mispredictions.

## Operation
- Lookup is combinational from `f_pc` and the current state.
  - BTB slot = `f_pc[IDX_W-1:0]`; tag = `f_pc[PC_W-1:IDX_W]`.
  - `f_taken = f_hit & ctr[f_index][CTR_W-1]`.
  - `f_next_pc = f_taken ? btb_target : f_pc + 1`, modulo 2^PC_W. `0xFF + 1` wraps to `0x00`.
- Update fires on the clock edge where `u_valid & enable & ~rst`.
  - Counter `ctr[u_index]`: increment if `u_taken`, else decrement. Saturates at `2^CTR_W-1` and at 0.
  - BTB slot `u_pc[IDX_W-1:0]`, written only if `u_taken`: valid=1, tag=`u_pc[PC_W-1:IDX_W]`, target=`u_target`. A not-taken update never allocates or invalidates an entry.
  - `stat_branches` increments by 1. `stat_mispredicts` increments by 1 when `u_mispredict`. Both saturate at all-ones.
  - GHR (gshare only): `{ghr[GHR_W-2:0], u_taken}`.
- Reset values: all BTB valid bits 0, tags 0, targets 0. Every counter = `2^(CTR_W-1)-1` (weakly not-taken; 0 when CTR_W=1). GHR=0, stats=0. Consequently, after reset `f_hit=0`, `f_taken=0`, `f_next_pc=f_pc+1`, `u_mispredict=u_valid&u_taken`.
- Reset has priority over a simultaneous update.
- `enable=0`: lookup outputs stay valid; updates, GHR and stats are held.

## Timing
- Lookup latency 0: combinational, same cycle as `f_pc`.
- Update latency 1: visible to lookup in the cycle after the update edge.
- No write-to-read bypass. A lookup in the update cycle sees the old state.
- Same-cycle lookup and update of the same slot is legal. The lookup returns the old entry.
- One update per cycle maximum. No handshake; `u_valid` is sampled every enabled edge.

## Configuration
- `BRANCH_PREDICTOR_GSHARE_EN` defined:
  - `f_index = f_pc[IDX_W-1:0] ^ {{(IDX_W-GHR_W){1'b0}}, ghr}`.
  - The GHR register exists and updates as above.
- Undefined:
  - `f_index = f_pc[IDX_W-1:0]`.
  - No GHR register is built. The counter table is indexed by PC only.
- BTB indexing is PC-only in both builds.

## Test plan
All scenarios use default parameters with gshare off unless noted.
- **Reset state:** reset, then `f_pc=0x23` → `f_hit=0`, `f_taken=0`, `f_next_pc=0x24`, `f_index=3`, both stats 0.
- **Allocate and predict:** update `u_pc=0x23`, `u_index=3`, `u_taken=1`, `u_target=0x40`, `u_pred=0`.
  - Same cycle: `u_mispredict=1`.
  - Next cycle, `f_pc=0x23` → `f_hit=1`, `f_taken=1`, `f_next_pc=0x40`.
  - Stats: branches=1, mispredicts=1.
- **Counter saturation:** 3 more taken updates to index 3 (counter 3), then one not-taken → `f_taken` still 1. Second not-taken → `f_taken=0`, `f_next_pc=0x24`, `f_hit` stays 1.
- **Tag mismatch and wrap:** `f_pc=0x33` → `f_hit=0`, `f_next_pc=0x34`. `f_pc=0xFF` after reset → `f_next_pc=0x00`.
- **Hold and reset priority:**
  - `enable=0` with `u_valid=1` → no state or stats change.
  - `rst=1` together with `u_valid=1` → all state returns to reset values.
- **Gshare build:** after taken updates with `u_pc` 0x10, 0x11, 0x12 (GHR=0b0111), `f_pc=0x23` → `f_index=3^7=4`.
